// File: rtl/dp_seq_if.sv
// Handshake and datapath-control bundle between the instruction sequencer and its host/datapath.
interface dp_seq_if;
    logic        start;
    logic [15:0] in;
    logic        w;
    logic        done;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  alu_op;
    logic [1:0]  shift;
    logic [15:0] sximm;

    modport master (
        output start, in,
        input  w, done, err, readnum, writenum, write,
        input  loada, loadb, loadc, loads, asel, bsel, vsel, alu_op, shift, sximm
    );

    modport slave (
        input  start, in,
        output w, done, err, readnum, writenum, write,
        output loada, loadb, loadc, loads, asel, bsel, vsel, alu_op, shift, sximm
    );
endinterface

// File: rtl/dp_seq.sv
// Multi-cycle instruction sequencer: latches an instruction and walks the datapath
// through read / ALU / writeback steps, emitting Moore control outputs.
module dp_seq #(
    parameter int unsigned IMM_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    dp_seq_if.slave  bus
);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_GET_A  = 3'd2;
    localparam logic [2:0] S_GET_B  = 3'd3;
    localparam logic [2:0] S_ALU    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [2:0] K_MOVI = 3'd0;
    localparam logic [2:0] K_MOVR = 3'd1;
    localparam logic [2:0] K_ADD  = 3'd2;
    localparam logic [2:0] K_CMP  = 3'd3;
    localparam logic [2:0] K_AND  = 3'd4;
    localparam logic [2:0] K_MVN  = 3'd5;
    localparam logic [2:0] K_ILL  = 3'd6;

    typedef struct packed {
        logic        w;
        logic        done;
        logic        err;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  vsel;
        logic [1:0]  alu_op;
        logic [1:0]  shift;
        logic [15:0] sximm;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{w: 1'b1, default: '0};

    logic [2:0]  state, state_n;
    logic [15:0] ir, ir_n;
    ctrl_t       ctrl, ctrl_n;
    logic [2:0]  cur_kind, nxt_kind;

    // Opcode/op pair to instruction class; anything outside the legal set is illegal.
    function automatic logic [2:0] kind(input logic [15:0] x);
        logic [2:0] k;
        case (x[15:11])
            5'b110_10: k = K_MOVI;
            5'b110_00: k = K_MOVR;
            5'b101_00: k = K_ADD;
            5'b101_01: k = K_CMP;
            5'b101_10: k = K_AND;
            5'b101_11: k = K_MVN;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    assign cur_kind = kind(ir);
    assign nxt_kind = kind(ir_n);

    // Next state and instruction latch; done/err flag the first cycle back in WAIT.
    always_comb begin
        state_n = S_WAIT;
        ir_n    = ir;
        ctrl_n  = '0;
        case (state)
            S_WAIT: begin
                if (bus.start) begin
                    state_n = S_DECODE;
                    ir_n    = bus.in;
                end
            end
            S_DECODE: begin
                case (cur_kind)
                    K_MOVI:              state_n = S_WB;
                    K_MOVR, K_MVN:       state_n = S_GET_B;
                    K_ADD, K_CMP, K_AND: state_n = S_GET_A;
                    default: begin
                        state_n    = S_WAIT;
                        ctrl_n.err = 1'b1;
                    end
                endcase
            end
            S_GET_A: state_n = S_GET_B;
            S_GET_B: state_n = S_ALU;
            S_ALU: begin
                if (cur_kind == K_CMP) begin
                    state_n     = S_WAIT;
                    ctrl_n.done = 1'b1;
                end else begin
                    state_n = S_WB;
                end
            end
            S_WB: begin
                state_n     = S_WAIT;
                ctrl_n.done = 1'b1;
            end
            default: state_n = S_WAIT;
        endcase

        // Outputs are decoded from the upcoming state/ir so they can be registered
        // while still behaving as a Moore function of the state actually entered.
        ctrl_n.w      = (state_n == S_WAIT);
        ctrl_n.alu_op = ir_n[12:11];
        ctrl_n.shift  = ir_n[4:3];
        ctrl_n.sximm  = 16'($signed(ir_n[IMM_W-1:0]));
        case (state_n)
            S_GET_A: begin
                ctrl_n.readnum = ir_n[10:8];
                ctrl_n.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_n.readnum = ir_n[2:0];
                ctrl_n.loadb   = 1'b1;
            end
            S_ALU: begin
                ctrl_n.asel = (nxt_kind == K_MOVR) || (nxt_kind == K_MVN);
                if (nxt_kind == K_CMP) ctrl_n.loads = 1'b1;
                else                   ctrl_n.loadc = 1'b1;
            end
            S_WB: begin
                ctrl_n.write = 1'b1;
                if (nxt_kind == K_MOVI) begin
                    ctrl_n.writenum = ir_n[10:8];
                    ctrl_n.vsel     = 2'b01;
                end else begin
                    ctrl_n.writenum = ir_n[7:5];
                    ctrl_n.vsel     = 2'b00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
            ctrl  <= CTRL_RST;
        end else begin
            state <= state_n;
            ir    <= ir_n;
            ctrl  <= ctrl_n;
        end
    end

    assign bus.w        = ctrl.w;
    assign bus.done     = ctrl.done;
    assign bus.err      = ctrl.err;
    assign bus.readnum  = ctrl.readnum;
    assign bus.writenum = ctrl.writenum;
    assign bus.write    = ctrl.write;
    assign bus.loada    = ctrl.loada;
    assign bus.loadb    = ctrl.loadb;
    assign bus.loadc    = ctrl.loadc;
    assign bus.loads    = ctrl.loads;
    assign bus.asel     = ctrl.asel;
    assign bus.bsel     = ctrl.bsel;
    assign bus.vsel     = ctrl.vsel;
    assign bus.alu_op   = ctrl.alu_op;
    assign bus.shift    = ctrl.shift;
    assign bus.sximm    = ctrl.sximm;

endmodule
